// File: rtl/vdp_vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vdp_vram_arbiter_pkg
// Shared definitions for the VDP VRAM arbiter:
//   - requester index constants (screen, sprite, cpu, command)
//   - arbiter FSM state type
//   - default VRAM byte address width (128 KB)
//   - helper to turn a requester index into a one-hot strobe vector
// No ports (package).
// -----------------------------------------------------------------------------
package vdp_vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 17;

    localparam logic [1:0] REQ_SCREEN  = 2'd0;
    localparam logic [1:0] REQ_SPRITE  = 2'd1;
    localparam logic [1:0] REQ_CPU     = 2'd2;
    localparam logic [1:0] REQ_COMMAND = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_READ_WAIT = 2'd2
    } state_t;

    function automatic logic [3:0] req_onehot(input logic [1:0] idx);
        req_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/vdp_vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vdp_vram_arbiter_if
// Bundles the requester-side and SDRAM-side signals of the VRAM arbiter.
//   Requester side : req[4], write[4], address[4*ADDR_W], wdata[32] in;
//                    ack[4], rdata_en[4], rdata[8], timeout_error out.
//   Memory side    : mem_valid, mem_write, mem_address, mem_wdata out;
//                    mem_ready, mem_rdata_en, mem_rdata in.
// Modports:
//   master - the arbiter (masters the SDRAM controller's VRAM port)
//   slave  - the environment (requesters plus SDRAM controller)
// -----------------------------------------------------------------------------
interface vdp_vram_arbiter_if
    import vdp_vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
);
    logic [3:0]          req;
    logic [3:0]          write;
    logic [4*ADDR_W-1:0] address;
    logic [31:0]         wdata;
    logic [3:0]          ack;
    logic [3:0]          rdata_en;
    logic [7:0]          rdata;
    logic                timeout_error;

    logic                mem_valid;
    logic                mem_ready;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_address;
    logic [7:0]          mem_wdata;
    logic                mem_rdata_en;
    logic [7:0]          mem_rdata;

    modport master (
        input  req, write, address, wdata,
        input  mem_ready, mem_rdata_en, mem_rdata,
        output ack, rdata_en, rdata, timeout_error,
        output mem_valid, mem_write, mem_address, mem_wdata
    );

    modport slave (
        output req, write, address, wdata,
        output mem_ready, mem_rdata_en, mem_rdata,
        input  ack, rdata_en, rdata, timeout_error,
        input  mem_valid, mem_write, mem_address, mem_wdata
    );

endinterface

// File: rtl/vdp_vram_priority_select.sv
// -----------------------------------------------------------------------------
// vdp_vram_priority_select
// Winner selection for the VRAM arbiter: fixed priority with an aged-CPU
// override and a cpu/command round-robin pair.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_req[3:0]       raw request vector (0 screen, 1 sprite, 2 cpu, 3 command)
//   i_idle           arbiter is in ST_IDLE and can accept a grant this cycle
//   o_grant_valid    at least one requester is asking
//   o_grant_index    index of the winning requester
//   o_update         grant taken this cycle (ack strobe); advances the
//                    round-robin pointer and clears the cpu aging counter
// -----------------------------------------------------------------------------
module vdp_vram_priority_select
    import vdp_vram_arbiter_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 64
)(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_req,
    input  logic       i_idle,
    output logic       o_grant_valid,
    output logic [1:0] o_grant_index,
    output logic       o_update
);

    localparam int               AGE_W   = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(CPU_MAX_WAIT);

    logic [AGE_W-1:0] r_age;
    logic             r_rr_cpu;     // 1: cpu wins a cpu/command tie, 0: command wins
    logic             w_cpu_aged;
    logic             w_cpu_ack;

    always_comb begin
        w_cpu_aged    = (r_age == AGE_MAX);
        o_grant_valid = |i_req;
        o_grant_index = REQ_SCREEN;

        if (i_req[REQ_SCREEN]) begin
            o_grant_index = REQ_SCREEN;
        end else if (i_req[REQ_CPU] && w_cpu_aged) begin
            // A CPU write starved by sprite traffic jumps ahead of sprite.
            o_grant_index = REQ_CPU;
        end else if (i_req[REQ_SPRITE]) begin
            o_grant_index = REQ_SPRITE;
        end else if (i_req[REQ_CPU] && i_req[REQ_COMMAND]) begin
            o_grant_index = r_rr_cpu ? REQ_CPU : REQ_COMMAND;
        end else if (i_req[REQ_CPU]) begin
            o_grant_index = REQ_CPU;
        end else if (i_req[REQ_COMMAND]) begin
            o_grant_index = REQ_COMMAND;
        end

        o_update  = o_grant_valid & i_idle;
        w_cpu_ack = o_update & (o_grant_index == REQ_CPU);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_age    <= '0;
            r_rr_cpu <= 1'b1;
        end else begin
            // Aging only measures the current uninterrupted wait.
            if (!i_req[REQ_CPU] || w_cpu_ack) begin
                r_age <= '0;
            end else if (r_age != AGE_MAX) begin
                r_age <= r_age + AGE_W'(1);
            end

            // Pointer moves to the other member of the pair only when one of
            // the pair is actually served (aged cpu grants included).
            if (o_update && (o_grant_index == REQ_CPU)) begin
                r_rr_cpu <= 1'b0;
            end else if (o_update && (o_grant_index == REQ_COMMAND)) begin
                r_rr_cpu <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// -----------------------------------------------------------------------------
// vdp_vram_arbiter
// Shares the single byte-wide VRAM port of the SDRAM controller among the
// four VDP requesters (screen, sprite, cpu, command). One access is in
// flight at a time: IDLE accepts a winner and acks it combinationally,
// ISSUE presents it to memory until mem_ready, READ_WAIT waits for read
// data or times out and returns 0xFF with a sticky error flag.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset; abandons any access in flight
//   bus      vdp_vram_arbiter_if.master - requester and memory signals
// -----------------------------------------------------------------------------
module vdp_vram_arbiter
    import vdp_vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int CPU_MAX_WAIT = 64,
    parameter int READ_TIMEOUT = 255
)(
    input  logic                 i_clk,
    input  logic                 i_reset,
    vdp_vram_arbiter_if.master   bus
);

    localparam int               TMO_W   = $clog2(READ_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(READ_TIMEOUT);

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_idx;
    logic               r_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rdata;
    logic [3:0]         r_rdata_en;
    logic               r_timeout_error;
    logic [TMO_W-1:0]   r_tmo;

    logic               w_idle;
    logic               w_grant_valid;
    logic [1:0]         w_grant_index;
    logic               w_update;
    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [7:0]         w_sel_wdata;
    logic               w_rd_done;
    logic               w_rd_timeout;

    assign w_idle = (r_state == ST_IDLE);

    vdp_vram_priority_select #(
        .CPU_MAX_WAIT (CPU_MAX_WAIT)
    ) u_sel (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_req         (bus.req),
        .i_idle        (w_idle),
        .o_grant_valid (w_grant_valid),
        .o_grant_index (w_grant_index),
        .o_update      (w_update)
    );

    // Field mux for the winning requester.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int n = 0; n < 4; n++) begin
            if (w_grant_index == 2'(n)) begin
                w_sel_write = bus.write[n];
                w_sel_addr  = bus.address[n*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.wdata[n*8 +: 8];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_rd_done    = 1'b0;
        w_rd_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ready) begin
                    w_state_next = r_write ? ST_IDLE : ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                // Real data wins over a timeout landing on the same cycle.
                if (bus.mem_rdata_en) begin
                    w_rd_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_tmo == TMO_MAX) begin
                    w_rd_timeout = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_write         <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_rdata         <= '0;
            r_rdata_en      <= '0;
            r_timeout_error <= 1'b0;
            r_tmo           <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rdata_en <= '0;

            if (w_update) begin
                r_idx   <= w_grant_index;
                r_write <= w_sel_write;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end

            // Counter is zero on the first READ_WAIT cycle.
            if (r_state == ST_ISSUE) begin
                r_tmo <= '0;
            end else if (r_state == ST_READ_WAIT) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (w_rd_done) begin
                r_rdata    <= bus.mem_rdata;
                r_rdata_en <= req_onehot(r_idx);
            end else if (w_rd_timeout) begin
                r_rdata         <= 8'hFF;
                r_rdata_en      <= req_onehot(r_idx);
                r_timeout_error <= 1'b1;
            end
        end
    end

    assign bus.ack           = w_update ? req_onehot(w_grant_index) : 4'b0000;
    assign bus.rdata_en      = r_rdata_en;
    assign bus.rdata         = r_rdata;
    assign bus.timeout_error = r_timeout_error;
    assign bus.mem_valid     = (r_state == ST_ISSUE);
    assign bus.mem_write     = r_write;
    assign bus.mem_address   = r_addr;
    assign bus.mem_wdata     = r_wdata;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vdp_vram_arbiter
// Scoreboard bench: stimulus pushes the expected ack order, memory accesses
// and read responses; a monitor on the falling edge pops and compares them
// whenever the arbiter presents the corresponding output.
// -----------------------------------------------------------------------------
module tb_vdp_vram_arbiter;
    import vdp_vram_arbiter_pkg::*;

    localparam int AW = 17;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
    } mem_t;

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] d;
    } rd_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vdp_vram_arbiter_if #(.ADDR_W(AW)) bus();

    vdp_vram_arbiter #(
        .ADDR_W       (AW),
        .CPU_MAX_WAIT (64),
        .READ_TIMEOUT (255)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    logic          t_req  [4];
    logic          t_wr   [4];
    logic [AW-1:0] t_addr [4];
    logic [7:0]    t_wd   [4];
    logic          t_mem_ready;
    logic          t_mem_rdata_en;
    logic [7:0]    t_mem_rdata;

    always_comb begin
        bus.req     = '0;
        bus.write   = '0;
        bus.address = '0;
        bus.wdata   = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req[i]             = t_req[i];
            bus.write[i]           = t_wr[i];
            bus.address[i*AW +: AW] = t_addr[i];
            bus.wdata[i*8 +: 8]    = t_wd[i];
        end
    end

    assign bus.mem_ready    = t_mem_ready;
    assign bus.mem_rdata_en = t_mem_rdata_en;
    assign bus.mem_rdata    = t_mem_rdata;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_ack [$];
    mem_t exp_mem [$];
    rd_t  exp_rd  [$];
    int   w0, w1, w2, w3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic mem_t mk_mem(input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
        mem_t m;
        m.wr   = wr;
        m.addr = a;
        m.wd   = d;
        return m;
    endfunction

    function automatic rd_t mk_rd(input logic [3:0] en, input logic [7:0] d);
        rd_t r;
        r.en = en;
        r.d  = d;
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) t_req[i] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Raise a request, hold it until acked, drop it after the accepting edge.
    // 'waited' returns the number of falling edges seen without ack.
    task automatic request(input int idx, input logic wr, input logic [AW-1:0] a,
                           input logic [7:0] d, output int waited);
        int n;
        n = 0;
        t_req[idx]  = 1'b1;
        t_wr[idx]   = wr;
        t_addr[idx] = a;
        t_wd[idx]   = d;
        forever begin
            @(negedge clk);
            if (bus.ack[idx]) break;
            n++;
            if (n > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_wait_bound: requester %0d got no ack in %0d cycles", idx, n);
                break;
            end
        end
        waited = n;
        @(posedge clk);
        #1;
        t_req[idx] = 1'b0;
    endtask

    // Scoreboard monitor.
    int         m_e;
    logic [3:0] m_oh;
    mem_t       m_mem;
    rd_t        m_rd;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ack != 4'b0000) begin
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", 32'(bus.ack), 32'd0);
                end else begin
                    m_e  = exp_ack.pop_front();
                    m_oh = 4'b0001 << m_e;
                    chk("ack_order", 32'(bus.ack), 32'(m_oh));
                end
            end
            if (bus.mem_valid && bus.mem_ready) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected", 32'(bus.mem_address), 32'hFFFF_FFFF);
                end else begin
                    m_mem = exp_mem.pop_front();
                    chk("mem_access", 32'({bus.mem_write, bus.mem_address, bus.mem_wdata}), 32'(m_mem));
                end
            end
            if (bus.rdata_en != 4'b0000) begin
                if (exp_rd.size() == 0) begin
                    chk("rdata_unexpected", 32'(bus.rdata_en), 32'd0);
                end else begin
                    m_rd = exp_rd.pop_front();
                    chk("read_resp", 32'({bus.rdata_en, bus.rdata}), 32'(m_rd));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        for (int i = 0; i < 4; i++) begin
            t_req[i]  = 1'b0;
            t_wr[i]   = 1'b0;
            t_addr[i] = '0;
            t_wd[i]   = '0;
        end
        t_mem_ready    = 1'b1;
        t_mem_rdata_en = 1'b0;
        t_mem_rdata    = '0;
        reset          = 1'b1;
        step(3);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ack",         32'(bus.ack), 32'd0);
        chk("rst_rdata_en",    32'(bus.rdata_en), 32'd0);
        chk("rst_rdata",       32'(bus.rdata), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_error), 32'd0);
        chk("rst_mem_valid",   32'(bus.mem_valid), 32'd0);
        chk("rst_mem_write",   32'(bus.mem_write), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_wdata",   32'(bus.mem_wdata), 32'd0);
        step(1);

        // Single CPU write
        exp_ack.push_back(2);
        exp_mem.push_back(mk_mem(1'b1, 17'h1B00, 8'h0C));
        request(2, 1'b1, 17'h1B00, 8'h0C, w2);
        chk("t1_ack_latency", 32'(w2), 32'd0);
        @(negedge clk);
        chk("t1_mem_valid",   32'(bus.mem_valid), 32'd1);
        chk("t1_mem_address", 32'(bus.mem_address), 32'h1B00);
        chk("t1_mem_wdata",   32'(bus.mem_wdata), 32'h0C);
        chk("t1_mem_write",   32'(bus.mem_write), 32'd1);
        @(negedge clk);
        chk("t1_back_idle",   32'(bus.mem_valid), 32'd0);
        step(1);

        // Sprite read with 3-cycle memory latency
        exp_ack.push_back(1);
        exp_mem.push_back(mk_mem(1'b0, 17'h3800, 8'h00));
        exp_rd.push_back(mk_rd(4'b0010, 8'hAA));
        request(1, 1'b0, 17'h3800, 8'h00, w1);
        @(negedge clk);
        chk("t2_mem_valid", 32'(bus.mem_valid), 32'd1);
        @(posedge clk);
        step(2);
        t_mem_rdata_en = 1'b1;
        t_mem_rdata    = 8'hAA;
        @(negedge clk);
        chk("t2_no_early_rdata_en", 32'(bus.rdata_en), 32'd0);
        @(posedge clk);
        #1;
        t_mem_rdata_en = 1'b0;
        t_mem_rdata    = 8'h00;
        @(negedge clk);
        chk("t2_rdata_en", 32'(bus.rdata_en), 32'h2);
        chk("t2_rdata",    32'(bus.rdata), 32'hAA);
        @(negedge clk);
        chk("t2_rdata_en_pulse", 32'(bus.rdata_en), 32'd0);
        step(1);

        // All four at once: screen, sprite, then cpu/command alternating
        do_reset();
        exp_ack.push_back(0); exp_mem.push_back(mk_mem(1'b1, 17'h00010, 8'h10));
        exp_ack.push_back(1); exp_mem.push_back(mk_mem(1'b1, 17'h00020, 8'h20));
        for (int k = 0; k < 3; k++) begin
            exp_ack.push_back(2); exp_mem.push_back(mk_mem(1'b1, 17'h300 + 17'(k), 8'h30 + 8'(k)));
            exp_ack.push_back(3); exp_mem.push_back(mk_mem(1'b1, 17'h400 + 17'(k), 8'h40 + 8'(k)));
        end
        fork
            request(0, 1'b1, 17'h00010, 8'h10, w0);
            request(1, 1'b1, 17'h00020, 8'h20, w1);
            begin
                for (int k = 0; k < 3; k++) request(2, 1'b1, 17'h300 + 17'(k), 8'h30 + 8'(k), w2);
            end
            begin
                for (int k = 0; k < 3; k++) request(3, 1'b1, 17'h400 + 17'(k), 8'h40 + 8'(k), w3);
            end
        join
        step(2);

        // Aging: sprite streams, cpu promoted after 64 cycles of waiting
        do_reset();
        for (int k = 0; k < 32; k++) begin
            exp_ack.push_back(1); exp_mem.push_back(mk_mem(1'b1, 17'h1000, 8'h11));
        end
        exp_ack.push_back(2); exp_mem.push_back(mk_mem(1'b1, 17'h1B00, 8'h5A));
        for (int k = 0; k < 2; k++) begin
            exp_ack.push_back(1); exp_mem.push_back(mk_mem(1'b1, 17'h1000, 8'h11));
        end
        fork
            begin
                for (int k = 0; k < 34; k++) request(1, 1'b1, 17'h1000, 8'h11, w1);
            end
            begin
                request(2, 1'b1, 17'h1B00, 8'h5A, w2);
                chk("t4_cpu_wait", 32'(w2), 32'd64);
                @(negedge clk);
                chk("t4_age_cleared", 32'(u_dut.u_sel.r_age), 32'd0);
            end
        join
        step(2);

        // Read timeout
        exp_ack.push_back(3);
        exp_mem.push_back(mk_mem(1'b0, 17'h0200, 8'h00));
        exp_rd.push_back(mk_rd(4'b1000, 8'hFF));
        request(3, 1'b0, 17'h0200, 8'h00, w3);
        @(negedge clk);
        chk("t5_mem_valid", 32'(bus.mem_valid), 32'd1);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n++;
            if (bus.rdata_en != 4'b0000) break;
        end
        chk("t5_timeout_cycles", 32'(n), 32'd257);
        chk("t5_rdata",          32'(bus.rdata), 32'hFF);
        chk("t5_timeout_err",    32'(bus.timeout_error), 32'd1);
        step(5);
        chk("t5_err_sticky",     32'(bus.timeout_error), 32'd1);
        exp_ack.push_back(0);
        exp_mem.push_back(mk_mem(1'b1, 17'h0050, 8'h77));
        request(0, 1'b1, 17'h0050, 8'h77, w0);
        step(2);
        chk("t5_err_after_write", 32'(bus.timeout_error), 32'd1);
        do_reset();
        @(negedge clk);
        chk("t5_err_cleared", 32'(bus.timeout_error), 32'd0);
        step(1);

        // Reset during ISSUE with mem_ready low, then a late mem_rdata_en
        t_mem_ready = 1'b0;
        exp_ack.push_back(2);
        request(2, 1'b0, 17'h0040, 8'h00, w2);
        @(negedge clk);
        chk("t6_mem_valid_issue", 32'(bus.mem_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        t_mem_ready = 1'b1;
        @(negedge clk);
        chk("t6_mem_valid_after_reset", 32'(bus.mem_valid), 32'd0);
        @(posedge clk);
        #1;
        t_mem_rdata_en = 1'b1;
        t_mem_rdata    = 8'h33;
        @(posedge clk);
        #1;
        t_mem_rdata_en = 1'b0;
        t_mem_rdata    = 8'h00;
        @(negedge clk);
        chk("t6_no_rdata_en", 32'(bus.rdata_en), 32'd0);
        chk("t6_rdata_zero",  32'(bus.rdata), 32'd0);
        step(3);

        chk("sb_ack_drained", 32'(exp_ack.size()), 32'd0);
        chk("sb_mem_drained", 32'(exp_mem.size()), 32'd0);
        chk("sb_rd_drained",  32'(exp_rd.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
